// File: rtl/fft_pkg.sv
// Shared definitions for the 512-point FFT output reorder path.
//
// Contents:
//   N, BLK_SIZE, DW, BEATS : frame geometry (BEATS is derived from N and BLK_SIZE)
//   sample_t               : one signed real or imaginary sample
//   bank_state_e           : lifecycle of one reorder bank
//   bitrev4/5/9            : index bit reversal helpers
package fft_pkg;

    localparam int N        = 512;
    localparam int BLK_SIZE = 16;
    localparam int DW       = 13;
    localparam int BEATS    = N / BLK_SIZE;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_e;

    function automatic logic [3:0] bitrev4(input logic [3:0] x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = x[3-i];
        end
        return r;
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = x[4-i];
        end
        return r;
    endfunction

    // Sequence index n = {beat[4:0], lane[3:0]} maps to bin {rev4(lane), rev5(beat)}.
    function automatic logic [8:0] bitrev9(input logic [8:0] n);
        return {bitrev4(n[3:0]), bitrev5(n[8:4])};
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of reorder storage plus its lifecycle state machine.
//
// A whole input beat (16 lanes, bit-reversed sequence order) is scattered
// into the frame in one cycle; a whole output row of 16 consecutive bins is
// read combinationally.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset (state only)
//   wr_en            write the current beat into this bank
//   wr_beat          input beat number 0..31
//   wr_i, wr_q       16-lane input samples
//   rd_hs            an output beat from this bank is handshaken this cycle
//   rd_beat          output row number 0..31
//   rd_i, rd_q       16 bins of row rd_beat, natural order
//   readable         bank is FULL or DRAINING
//   free             bank is EMPTY, or releases its last row this cycle
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_en,
    input  logic [4:0]  wr_beat,
    input  sample_t     wr_i [BLK_SIZE],
    input  sample_t     wr_q [BLK_SIZE],
    input  logic        rd_hs,
    input  logic [4:0]  rd_beat,
    output sample_t     rd_i [BLK_SIZE],
    output sample_t     rd_q [BLK_SIZE],
    output logic        readable,
    output logic        free
);

    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    bank_state_e state_q;
    bank_state_e state_d;
    logic        release_now;

    // Frame storage, indexed by natural bin number; contents are never reset.
    sample_t     frame_i_q [N];
    sample_t     frame_q_q [N];

    assign release_now = (state_q == DRAINING) && rd_hs && (rd_beat == LAST_BEAT);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. The read side is evaluated first so that a bank released
    // on this edge can immediately accept the first beat of a new frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FULL: begin
                if (rd_hs) begin
                    state_d = DRAINING;
                end
            end
            DRAINING: begin
                if (release_now) begin
                    state_d = EMPTY;
                end
            end
            default: begin
            end
        endcase

        if (wr_en) begin
            if ((wr_beat == '0) && (state_d == EMPTY)) begin
                state_d = FILLING;
            end else if ((wr_beat == LAST_BEAT) && (state_q == FILLING)) begin
                state_d = FULL;
            end
        end
    end

    // Outputs
    assign readable = (state_q == FULL) || (state_q == DRAINING);
    assign free     = (state_q == EMPTY) || release_now;

    always_comb begin
        for (int j = 0; j < BLK_SIZE; j++) begin
            rd_i[j] = frame_i_q[{rd_beat, 4'(j)}];
            rd_q[j] = frame_q_q[{rd_beat, 4'(j)}];
        end
    end

    // Column write: each lane lands on its own bit-reversed bin.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < BLK_SIZE; l++) begin
                frame_i_q[bitrev9({wr_beat, 4'(l)})] <= wr_i[l];
                frame_q_q[bitrev9({wr_beat, 4'(l)})] <= wr_q[l];
            end
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 512-point FFT output.
//
// Two banks are used ping-pong: the write side fills bank wr_sel while the
// read side drains bank rd_sel. A frame that starts while its target bank is
// still occupied is dropped whole and flagged by the sticky overflow output.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_valid          input beat valid (no backpressure)
//   din_i, din_q     16-lane input real / imaginary, bit-reversed order
//   o_valid, o_ready output handshake
//   dout_i, dout_q   16 bins per beat, natural order, zero when not valid
//   o_sof, o_eof     first / last output beat of a frame
//   overflow         sticky: an input frame was dropped
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    i_valid,
    input  sample_t din_i [BLK_SIZE],
    input  sample_t din_q [BLK_SIZE],
    output logic    o_valid,
    input  logic    o_ready,
    output sample_t dout_i [BLK_SIZE],
    output sample_t dout_q [BLK_SIZE],
    output logic    o_sof,
    output logic    o_eof,
    output logic    overflow
);

    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    logic [4:0] wcnt_q, wcnt_d;
    logic [4:0] rcnt_q, rcnt_d;
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic       drop_q, drop_d;
    logic       overflow_q, overflow_d;

    logic       frame_start;
    logic       accept;
    logic       wr_en;
    logic       rd_hs;

    logic [1:0] bank_wr_en;
    logic [1:0] bank_rd_hs;
    logic [1:0] bank_readable;
    logic [1:0] bank_free;
    sample_t    bank_rd_i [2][BLK_SIZE];
    sample_t    bank_rd_q [2][BLK_SIZE];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank u_bank (
            .clk      (clk),
            .rstn     (rstn),
            .wr_en    (bank_wr_en[b]),
            .wr_beat  (wcnt_q),
            .wr_i     (din_i),
            .wr_q     (din_q),
            .rd_hs    (bank_rd_hs[b]),
            .rd_beat  (rcnt_q),
            .rd_i     (bank_rd_i[b]),
            .rd_q     (bank_rd_q[b]),
            .readable (bank_readable[b]),
            .free     (bank_free[b])
        );
    end

    // Write side. The accept/drop decision is made on beat 0 and held in
    // drop_q for the remaining 31 beats of the frame.
    always_comb begin
        frame_start = i_valid && (wcnt_q == '0);
        accept      = bank_free[wr_sel_q];
        wr_en       = i_valid && (frame_start ? accept : !drop_q);
        wcnt_d      = i_valid ? wcnt_q + 5'd1 : wcnt_q;
        drop_d      = frame_start ? !accept : drop_q;
        wr_sel_d    = (wr_en && (wcnt_q == LAST_BEAT)) ? !wr_sel_q : wr_sel_q;
        overflow_d  = overflow_q | (frame_start & !accept);
        bank_wr_en  = {wr_en & wr_sel_q, wr_en & !wr_sel_q};
    end

    // Read side
    assign o_valid    = bank_readable[rd_sel_q];
    assign rd_hs      = o_valid && o_ready;
    assign bank_rd_hs = {rd_hs & rd_sel_q, rd_hs & !rd_sel_q};

    always_comb begin
        rcnt_d   = rd_hs ? rcnt_q + 5'd1 : rcnt_q;
        rd_sel_d = (rd_hs && (rcnt_q == LAST_BEAT)) ? !rd_sel_q : rd_sel_q;
        o_sof    = o_valid && (rcnt_q == '0);
        o_eof    = o_valid && (rcnt_q == LAST_BEAT);
        // Data is forced to zero outside valid beats so reset clears it at once.
        for (int j = 0; j < BLK_SIZE; j++) begin
            dout_i[j] = o_valid ? bank_rd_i[rd_sel_q][j] : '0;
            dout_q[j] = o_valid ? bank_rd_q[rd_sel_q][j] : '0;
        end
    end

    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: a frame-level reference model (queue of
// expected natural-order bins, count of frames held) checked every cycle,
// plus literal spot values for the known ramp pattern.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    logic    clk = 1'b0;
    logic    rstn = 1'b0;
    logic    i_valid = 1'b0;
    logic    o_ready = 1'b0;
    sample_t din_i [BLK_SIZE];
    sample_t din_q [BLK_SIZE];
    sample_t dout_i [BLK_SIZE];
    sample_t dout_q [BLK_SIZE];
    logic    o_valid, o_sof, o_eof, overflow;

    fft_bitrev_reorder dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_valid  (i_valid),
        .din_i    (din_i),
        .din_q    (din_q),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .dout_i   (dout_i),
        .dout_q   (dout_q),
        .o_sof    (o_sof),
        .o_eof    (o_eof),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    // Reference model state
    int exp_i[$];
    int exp_q[$];
    int pending = 0;
    int out_beat = 0;
    int hs_total = 0;
    int m_beat = 0;
    bit m_drop = 1'b0;
    bit m_ovf = 1'b0;
    int in_i [N];
    int in_q [N];
    int bad;
    int lane;

    bit cap_en = 1'b0;
    int cap_i [BEATS][BLK_SIZE];
    int cap_q [BEATS][BLK_SIZE];
    int last_in_cyc = -1;
    int first_vld_cyc = -1;

    function automatic int rev9(input int x);
        int r = 0;
        for (int i = 0; i < 9; i++) begin
            if (((x >> i) & 1) != 0) r = r | (1 << (8 - i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // o_ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: o_ready = 1'b1;
                1: o_ready = ((cyc % 3) == 0);
                2: o_ready = 1'b0;
                default: o_ready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Compare process: at each falling edge the inputs and outputs that the
    // next rising edge will act on are stable.
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            exp_i.delete();
            exp_q.delete();
            pending = 0;
            out_beat = 0;
            m_beat = 0;
            m_drop = 1'b0;
            m_ovf = 1'b0;
            chk("rst_o_valid", int'(o_valid), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_o_sof", int'(o_sof), 0);
            chk("rst_o_eof", int'(o_eof), 0);
        end else begin
            chk("o_valid", int'(o_valid), int'(pending > 0));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (o_valid && pending > 0) begin
                bad = -1;
                for (int j = 0; j < BLK_SIZE; j++) begin
                    if (bad < 0 && (int'(dout_i[j]) != exp_i[j] || int'(dout_q[j]) != exp_q[j]))
                        bad = j;
                end
                lane = (bad < 0) ? 0 : bad;
                chk($sformatf("dout_i beat%0d lane%0d", out_beat, lane), int'(dout_i[lane]), exp_i[lane]);
                chk($sformatf("dout_q beat%0d lane%0d", out_beat, lane), int'(dout_q[lane]), exp_q[lane]);
                chk("o_sof", int'(o_sof), int'(out_beat == 0));
                chk("o_eof", int'(o_eof), int'(out_beat == BEATS - 1));
                if (cap_en && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (o_ready) begin
                    if (cap_en) begin
                        for (int j = 0; j < BLK_SIZE; j++) begin
                            cap_i[out_beat][j] = int'(dout_i[j]);
                            cap_q[out_beat][j] = int'(dout_q[j]);
                        end
                    end
                    repeat (BLK_SIZE) begin
                        void'(exp_i.pop_front());
                        void'(exp_q.pop_front());
                    end
                    hs_total++;
                    out_beat++;
                    if (out_beat == BEATS) begin
                        out_beat = 0;
                        pending--;
                        cap_en = 1'b0;
                    end
                end
            end
            if (i_valid) begin
                if (m_beat == 0) begin
                    // Two frames waiting or draining means no room for a third.
                    m_drop = (pending >= 2);
                    if (m_drop) m_ovf = 1'b1;
                end
                if (!m_drop) begin
                    for (int l = 0; l < BLK_SIZE; l++) begin
                        in_i[BLK_SIZE * m_beat + l] = int'(din_i[l]);
                        in_q[BLK_SIZE * m_beat + l] = int'(din_q[l]);
                    end
                end
                if (m_beat == BEATS - 1) begin
                    last_in_cyc = cyc;
                    if (!m_drop) begin
                        for (int k = 0; k < N; k++) begin
                            exp_i.push_back(in_i[rev9(k)]);
                            exp_q.push_back(in_q[rev9(k)]);
                        end
                        pending++;
                    end
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // mode 0: ramp din_i = 16b+l, din_q = -(16b+l); mode 1: random samples.
    task automatic send_frame(input int mode, input int gap_pct);
        int v;
        for (int b = 0; b < BEATS; b++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int l = 0; l < BLK_SIZE; l++) begin
                if (mode == 0) begin
                    v = BLK_SIZE * b + l;
                    din_i[l] = sample_t'(v);
                    din_q[l] = sample_t'(-v);
                end else begin
                    din_i[l] = sample_t'(int'($urandom_range(0, 8191)) - 4096);
                    din_q[l] = sample_t'(int'($urandom_range(0, 8191)) - 4096);
                end
            end
            i_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (pending == 0 && !o_valid) break;
        end
        if (k == budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: pending=%0d, expected 0", pending);
        end
    endtask

    task automatic check_ramp_spots(input string tag);
        chk({tag, " b0l0 i"}, cap_i[0][0], 0);
        chk({tag, " b0l1 i"}, cap_i[0][1], 256);
        chk({tag, " b0l2 i"}, cap_i[0][2], 128);
        chk({tag, " b0l3 i"}, cap_i[0][3], 384);
        chk({tag, " b1l0 i"}, cap_i[1][0], 16);
        chk({tag, " b31l15 i"}, cap_i[31][15], 511);
        chk({tag, " b31l15 q"}, cap_q[31][15], -511);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int k;
        for (int l = 0; l < BLK_SIZE; l++) begin
            din_i[l] = '0;
            din_q[l] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single ramp frame, always ready
        ready_mode = 0;
        cap_en = 1'b1;
        first_vld_cyc = -1;
        send_frame(0, 0);
        wait_idle(200);
        chk("latency", first_vld_cyc - last_in_cyc, 1);
        check_ramp_spots("s1");

        // Two back-to-back random frames
        h0 = hs_total;
        send_frame(1, 0);
        send_frame(1, 0);
        wait_idle(300);
        chk("s2 handshakes", hs_total - h0, 64);
        chk("s2 overflow", int'(overflow), 0);

        // Ready toggling 1,0,0
        ready_mode = 1;
        cap_en = 1'b1;
        h0 = hs_total;
        send_frame(0, 0);
        wait_idle(400);
        chk("s3 handshakes", hs_total - h0, 32);
        check_ramp_spots("s3");

        // Single-cycle gaps inside the frame
        ready_mode = 0;
        cap_en = 1'b1;
        send_frame(0, 30);
        wait_idle(200);
        check_ramp_spots("s5");

        // Three frames with no drain: third is dropped
        ready_mode = 2;
        send_frame(1, 0);
        send_frame(1, 0);
        send_frame(1, 0);
        @(posedge clk);
        #1;
        chk("s4 overflow", int'(overflow), 1);
        h0 = hs_total;
        ready_mode = 0;
        wait_idle(300);
        chk("s4 handshakes", hs_total - h0, 64);
        chk("s4 overflow sticky", int'(overflow), 1);

        // Reset at output beat 10
        send_frame(0, 0);
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (out_beat == 10 && pending > 0) break;
        end
        chk("s6 reached beat 10", out_beat, 10);
        rstn = 1'b0;
        #1;
        chk("s6 async o_valid", int'(o_valid), 0);
        chk("s6 async o_sof", int'(o_sof), 0);
        chk("s6 async o_eof", int'(o_eof), 0);
        chk("s6 async overflow", int'(overflow), 0);
        chk("s6 async dout_i0", int'(dout_i[0]), 0);
        chk("s6 async dout_q5", int'(dout_q[5]), 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        cap_en = 1'b1;
        send_frame(0, 0);
        wait_idle(200);
        check_ramp_spots("s6");

        // Random traffic: random data, gaps, idle spacing and ready
        ready_mode = 3;
        for (int f = 0; f < 8; f++) begin
            send_frame(1, 20);
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
        end
        ready_mode = 0;
        wait_idle(600);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side consumer for the 512-point FFT core.
- Accepts the core's 32 beats x 16 lanes of 13-bit complex results, which arrive in bit-reversed order, and replays each frame in natural frequency order (16 bins/beat) with a valid/ready handshake.
- Two-frame ping-pong buffer, so back-to-back FFT frames are absorbed while the downstream drains.

Parameters:
- N, 512, points per frame.
- BLK_SIZE, 16, samples per beat (lanes).
- DW, 13, signed sample width, real and imaginary.
- BEATS, N/BLK_SIZE = 32, beats per frame (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid; no backpressure towards the FFT.
- din_i  in  [BLK_SIZE] x DW signed  input real, lanes 0..15.
- din_q  in  [BLK_SIZE] x DW signed  input imaginary.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts the beat when o_valid and o_ready are both high.
- dout_i  out  [BLK_SIZE] x DW signed  output real, natural order.
- dout_q  out  [BLK_SIZE] x DW signed  output imaginary.
- o_sof  out  1  high on output beat 0 of a frame.
- o_eof  out  1  high on output beat 31 of a frame.
- overflow  out  1  sticky: an input frame was dropped.

Behaviour:
- Index mapping
  - Input beat b (0..31), lane l carries sequence index n = 16b + l.
  - Its natural bin is k = bitrev9(n) = {rev4(l), rev5(b)}.
  - Output beat m, lane j carries bin k = 16m + j.
- Storage: two banks, each N complex entries held in flops. The write of a beat sets 16 entries in one cycle.
- Bank state machine, per bank: EMPTY -> FILLING (first beat accepted) -> FULL (32nd beat written) -> DRAINING (first output beat) -> EMPTY (beat 31 handshaken).
- Write side
  - 5-bit write beat counter wcnt, incremented on every i_valid, wraps 31 -> 0.
  - When wcnt==0 and i_valid: the frame is accepted if bank wr_sel is EMPTY. Otherwise the whole frame is tagged drop, all 32 beats are counted but not stored, and overflow is set.
  - Gaps in i_valid are allowed; the counter simply holds.
  - wr_sel toggles after an accepted frame completes.
- Read side
  - 5-bit read counter rcnt, bank rd_sel.
  - o_valid = 1 while bank rd_sel is FULL or DRAINING.
  - Latency: the 32nd input beat is sampled at edge T; o_valid is high in the cycle following edge T (1-cycle latency), provided the bank is next in read order.
  - rcnt advances only on handshake. dout_*, o_sof and o_eof are held stable while o_valid && !o_ready.
  - After the beat-31 handshake, the bank goes EMPTY and rd_sel toggles. If the other bank is already FULL, o_valid stays high with no bubble.
- Simultaneous events
  - A bank going EMPTY on the same edge its peer's first beat arrives: both transitions occur.
  - A frame start seen on the same edge the write bank becomes EMPTY counts as EMPTY, i.e. read release takes effect first.
- Arithmetic: none. Data is copied bit-exact; no saturation or rescaling.
- Reset (rstn low, any time, including mid-fill or mid-drain)
  - Both banks EMPTY; wcnt = rcnt = 0; wr_sel = rd_sel = 0.
  - o_valid, o_sof, o_eof, overflow = 0.
  - Buffer contents are don't-care and are not reset.
- overflow clears only on reset.

Decomposition:
- Shared package fft_pkg holds:
  - N, BLK_SIZE, DW, BEATS;
  - typedef sample_t (signed [DW-1:0]);
  - typedef bank_state_e {EMPTY, FILLING, FULL, DRAINING};
  - functions bitrev4, bitrev5, bitrev9.
- One sub-module: fft_reorder_bank. It holds one frame plus its state machine, has a 16-lane column-write port and a 16-lane row-read port, and is instantiated twice.

Test Plan:
- Single frame, o_ready = 1; input din_i[l] = 16b + l, din_q[l] = -(16b + l):
  - o_valid rises 1 cycle after the last input beat.
  - Beat 0 lanes 0..3: dout_i = 0, 256, 128, 384.
  - Beat 1 lane 0: dout_i = 16.
  - Beat 31 lane 15: dout_i = 511, dout_q = -511.
  - o_sof on beat 0, o_eof on beat 31.
- Two back-to-back frames, o_ready = 1: 64 contiguous o_valid beats, no bubble at the frame boundary, overflow = 0, frame-2 data correct.
- Same as the single-frame test but o_ready toggling 1,0,0,1,…: each beat is held stable while stalled; exactly 32 handshakes occur and the data sequence is unchanged.
- Three frames with o_ready = 0 throughout:
  - overflow = 1 after the first beat of frame 3.
  - Then o_ready = 1 drains exactly frames 1 and 2 (64 beats) and frame 3 never appears.
- i_valid with random single-cycle gaps inside a frame: output identical to the first scenario.
- rstn pulsed low at output beat 10 of frame 1:
  - All outputs 0 immediately (asynchronous).
  - A fresh frame afterwards is reproduced correctly from output beat 0.
